multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control unit for the multicycle ARM-subset core. It decodes the latched instruction, sequences the shared datapath (ALU, register file, FPU, memory address path) through a Moore FSM, and holds the NZCV condition-flag register. It drives every datapath control input and evaluates conditional execution, including a configurable multi-cycle FPU execute phase.

Parameters:
FPU_LAT, 1, cycles spent in FPU execute state (1..15); register write occurs only on the last one.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
Instr  input  32  instruction-register contents
ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
PCWrite  output  1  PC register enable
MemWrite  output  1  data-memory write strobe
RegWrite  output  1  register-file write enable
IRWrite  output  1  instruction-register enable
FPUWrite  output  1  FPU result commit strobe
AdrSrc  output  1  0=PC, 1=Result as memory address
RegSrc  output  2  [0]=read R15 on port 1 (branch), [1]=read Rd on port 2 (store)
ALUSrcA  output  2  00=A, 01=PC
ALUSrcB  output  2  00=WriteData, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult, 11=FPUResult
ImmSrc  output  2  equals Instr[27:26]
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL
State  output  4  current FSM state, for debug

Behaviour:
- Decode fields: Op=Instr[27:26], I=Instr[25], L/S=Instr[20], cmd=Instr[24:21], cond=Instr[31:28], Rd=Instr[15:12].
- Instruction classes: Op 00 data-processing; MUL when I=0 and Instr[7:4]=1001. Op 01 LDR (L=1) / STR (L=0). Op 10 branch. Op 11 FPU.
- cmd mapping: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP. CMP uses SUB with no register write. Any other cmd is treated as a NOP.
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXECR(6), EXECI(7), ALUWB(8), BRANCH(9), FPUEX(10).
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10 (provides R15=PC+8).
  - Evaluates CondEx from the flag register, standard ARM codes 0000..1110.
  - CondEx=0, cond=1111, or an unsupported instruction: next state FETCH, no writes.
  - Otherwise: Op01→MEMADR; Op00 with I=1→EXECI; Op00 with I=0→EXECR; Op10→BRANCH; Op11→FPUEX.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Next state MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. If Rd=15, PCWrite=1 as well. Next state FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state FETCH.
- EXECR/EXECI: ALUSrcA=00, ALUSrcB=00/01, ALUControl per cmd or MUL. Next state ALUWB.
  - At the clock edge, if S=1: N,Z ← ALUFlags[3:2].
  - C,V ← ALUFlags[1:0] only for ADD/SUB/CMP.
- ALUWB: ResultSrc=00. RegWrite=1 unless CMP. PCWrite=1 if Rd=15 and not CMP. Next state FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. Next state FETCH.
- FPUEX: ResultSrc=11. A 4-bit counter counts 0..FPU_LAT-1. RegWrite=1 and FPUWrite=1 only when count=FPU_LAT-1, then next state FETCH.
- RegSrc: [0]=(Op=10), [1]=(Op=01 and L=0). RegSrc and ImmSrc are derived from Instr in all states.
- Every output not listed for a state is 0.
- Latency in cycles: B 3, STR 4, DP/MUL/CMP 4, LDR 5, FPU 2+FPU_LAT, condition-failed or NOP 2.
- Reset: while reset=0, all write enables (PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite) are forced to 0 combinationally. At the clock edge: state←FETCH, NZCV←0000, counter←0. Reset takes priority in any state, including mid-FPUEX.
- Flags never change outside EXECR/EXECI. The condition check in DECODE always sees flags from earlier instructions.

Test Plan:
- Reset low 2 cycles, then E2811005 (ADD R1,R1,#5) → states 0,1,7,8. ALUControl=000 and ALUSrcB=01 in EXECI; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- E5912004 (LDR) → states 0,1,2,3,4. AdrSrc=1 in MEMRD; ResultSrc=01 with RegWrite=1 in MEMWB; total 5 cycles.
- E5812000 (STR) → RegSrc=10, ImmSrc=01; MemWrite=1 for exactly one cycle in state 5; RegWrite never asserted.
- E2511001 (SUBS) with ALUFlags=0100 in EXECI → Z=1.
  - Then 0A000002 (BEQ) → BRANCH with PCWrite=1.
  - Then 1A000002 (BNE) → DECODE→FETCH with no writes.
- FPU_LAT=3, instr EE412003 → FPUEX held 3 cycles; RegWrite=FPUWrite=1 only in the third, ResultSrc=11.
- Assert reset=0 during MEMRD of an LDR → all write enables 0 that cycle; next state FETCH; flags 0000; no MEMWB occurs.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control unit of the multicycle ARM-subset core.
// A Moore FSM sequences the shared datapath. Control outputs are registered
// and are computed from the state being entered. The NZCV flag register and
// the FPU execute-cycle counter also live here. Write enables are gated
// combinationally by the active-low reset.
module multicycle_ctrl #(
  parameter int unsigned FPU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        FPUWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FPUEX  = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       fpu_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  // Index of the FPU execute cycle that commits the result.
  localparam logic [3:0] LAST_CNT = 4'(FPU_LAT - 1);

  // MUL shares Op=00 with data processing; distinguished by I=0 and bits [7:4]=1001.
  function automatic logic is_mul(input logic [31:0] ins);
    return (ins[25] == 1'b0) && (ins[7:4] == 4'b1001);
  endfunction

  function automatic logic [2:0] alu_op(input logic [31:0] ins);
    logic [2:0] op;
    if (is_mul(ins)) begin
      op = ALU_MUL;
    end else begin
      case (ins[24:21])
        4'b0100: op = ALU_ADD;
        4'b0010: op = ALU_SUB;
        4'b0000: op = ALU_AND;
        4'b1100: op = ALU_ORR;
        4'b1010: op = ALU_SUB;   // CMP is a SUB without write-back
        default: op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

  // Data-processing commands this core implements; anything else is a NOP.
  function automatic logic dp_known(input logic [31:0] ins);
    logic known;
    case (ins[24:21])
      4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010: known = 1'b1;
      default:                                     known = 1'b0;
    endcase
    return known | is_mul(ins);
  endfunction

  function automatic logic is_cmp(input logic [31:0] ins);
    return (ins[27:26] == 2'b00) && !is_mul(ins) && (ins[24:21] == 4'b1010);
  endfunction

  // Only the arithmetic commands produce meaningful carry/overflow.
  function automatic logic sets_cv(input logic [31:0] ins);
    logic cv;
    case (ins[24:21])
      4'b0100, 4'b0010, 4'b1010: cv = 1'b1;
      default:                   cv = 1'b0;
    endcase
    return cv & !is_mul(ins);
  endfunction

  // Standard ARM condition evaluation; 1111 never executes.
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = c & !z;
      4'b1001: r = !c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Control word presented while the FSM sits in state st.
  function automatic ctrl_t ctrl_for(input state_t st, input logic [31:0] ins, input logic last);
    ctrl_t c;
    logic  rd15;
    c    = '0;
    rd15 = (ins[15:12] == 4'd15);
    case (st)
      S_FETCH: begin
        c.pc_write   = 1'b1;
        c.ir_write   = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR: begin
        c.alu_src_b  = 2'b01;
      end
      S_MEMRD: begin
        c.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.pc_write   = rd15;
      end
      S_MEMWR: begin
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_control = alu_op(ins);
      end
      S_EXECI: begin
        c.alu_src_b   = 2'b01;
        c.alu_control = alu_op(ins);
      end
      S_ALUWB: begin
        c.reg_write  = !is_cmp(ins);
        c.pc_write   = rd15 & !is_cmp(ins);
      end
      S_BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.pc_write   = 1'b1;
      end
      S_FPUEX: begin
        c.result_src = 2'b11;
        c.reg_write  = last;
        c.fpu_write  = last;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  ctrl_t      ctrl_q, ctrl_d;

  // Next state, counter, flags and the control word of the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_ok(Instr[31:28], flags_q) ||
            ((Instr[27:26] == 2'b00) && !dp_known(Instr))) begin
          state_d = S_FETCH;
        end else begin
          case (Instr[27:26])
            2'b01:   state_d = S_MEMADR;
            2'b00:   state_d = Instr[25] ? S_EXECI : S_EXECR;
            2'b10:   state_d = S_BRANCH;
            default: begin
              state_d = S_FPUEX;
              cnt_d   = 4'd0;
            end
          endcase
        end
      end
      S_MEMADR: begin
        state_d = Instr[20] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
      end
      S_EXECR, S_EXECI: begin
        state_d = S_ALUWB;
        if (Instr[20]) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (sets_cv(Instr)) begin
            flags_d[1:0] = ALUFlags[1:0];
          end else begin
            flags_d[1:0] = flags_q[1:0];
          end
        end else begin
          flags_d = flags_q;
        end
      end
      S_FPUEX: begin
        if (cnt_q >= LAST_CNT) begin
          state_d = S_FETCH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_FETCH;   // MEMWB, MEMWR, ALUWB, BRANCH all return to fetch
      end
    endcase
    ctrl_d = ctrl_for(state_d, Instr, cnt_d == LAST_CNT);
  end

  // FSM state, flags, counter and registered control outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
      flags_q <= 4'b0000;
      ctrl_q  <= ctrl_for(S_FETCH, Instr, 1'b0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign PCWrite    = ctrl_q.pc_write  & reset;
  assign MemWrite   = ctrl_q.mem_write & reset;
  assign RegWrite   = ctrl_q.reg_write & reset;
  assign IRWrite    = ctrl_q.ir_write  & reset;
  assign FPUWrite   = ctrl_q.fpu_write & reset;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUControl = ctrl_q.alu_control;
  assign RegSrc     = {(Instr[27:26] == 2'b01) & ~Instr[20], (Instr[27:26] == 2'b10)};
  assign ImmSrc     = Instr[27:26];
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle expected state/control words are
// queued for each instruction and popped and compared cycle by cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr = 32'd0;
  logic [3:0]  ALUFlags = 4'd0;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  multicycle_ctrl #(.FPU_LAT(3)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .FPUWrite(FPUWrite), .AdrSrc(AdrSrc),
    .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
    bit          rst;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {PCWrite,MemWrite,RegWrite,IRWrite,FPUWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
  function automatic logic [14:0] mk(input logic pcw, input logic memw, input logic regw,
                                     input logic irw, input logic fpuw, input logic adr,
                                     input logic [1:0] asa, input logic [1:0] asb,
                                     input logic [1:0] rs, input logic [2:0] alu);
    return {pcw, memw, regw, irw, fpuw, adr, asa, asb, rs, alu};
  endfunction

  task automatic push(input logic [3:0] st, input logic [14:0] ctl, input bit rst = 1'b0);
    exp_t e;
    e.st = st; e.ctl = ctl; e.rst = rst;
    sb_q.push_back(e);
  endtask

  task automatic push_fd();
    push(4'd0, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000));
    push(4'd1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000));
  endtask

  function automatic logic [14:0] c_memadr();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000);
  endfunction
  function automatic logic [14:0] c_memrd();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [14:0] c_memwb(input logic pcw);
    return mk(pcw, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b000);
  endfunction
  function automatic logic [14:0] c_memwr();
    return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [14:0] c_exec(input logic [1:0] asb, input logic [2:0] alu);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, asb, 2'b00, alu);
  endfunction
  function automatic logic [14:0] c_aluwb(input logic regw, input logic pcw);
    return mk(pcw, 1'b0, regw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [14:0] c_branch();
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000);
  endfunction
  function automatic logic [14:0] c_fpu(input logic last);
    return mk(1'b0, 1'b0, last, 1'b0, last, 1'b0, 2'b00, 2'b00, 2'b11, 3'b000);
  endfunction

  // Compare one cycle of DUT outputs against the queue head.
  task automatic sample(input string tag, input logic [3:0] st, input logic [14:0] ctl);
    logic [18:0] obs;
    logic [3:0]  exp_src;
    obs = {State, PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
    check_eq({tag, " ctl"}, {13'd0, obs}, {13'd0, st, ctl});
    exp_src[3]   = (Instr[27:26] == 2'b01) && (Instr[20] == 1'b0);
    exp_src[2]   = (Instr[27:26] == 2'b10);
    exp_src[1:0] = Instr[27:26];
    check_eq({tag, " src"}, {28'd0, RegSrc, ImmSrc}, {28'd0, exp_src});
  endtask

  // Drain the queued expectations; the instruction register loads after FETCH.
  task automatic run(input string name, input logic [31:0] ins);
    int   k;
    exp_t e;
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.rst) begin
        @(posedge clk); #2;
        reset = 1'b0;
      end
      @(negedge clk); #1;
      sample($sformatf("%s c%0d", name, k), e.st, e.ctl);
      if (k == 0) Instr = ins;
      if (e.rst) begin
        @(posedge clk); #2;
        reset = 1'b1;
      end
      k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    sample("reset", 4'd0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000));
    @(posedge clk); #2;
    reset = 1'b1;

    ALUFlags = 4'b0000;
    push_fd(); push(4'd7, c_exec(2'b01, 3'b000)); push(4'd8, c_aluwb(1'b1, 1'b0));
    run("add", 32'hE2811005);

    push_fd(); push(4'd2, c_memadr()); push(4'd3, c_memrd()); push(4'd4, c_memwb(1'b0));
    run("ldr", 32'hE5912004);

    push_fd(); push(4'd2, c_memadr()); push(4'd5, c_memwr());
    run("str", 32'hE5812000);

    ALUFlags = 4'b0100;
    push_fd(); push(4'd7, c_exec(2'b01, 3'b001)); push(4'd8, c_aluwb(1'b1, 1'b0));
    run("subs", 32'hE2511001);
    ALUFlags = 4'b0000;

    push_fd(); push(4'd9, c_branch());
    run("beq", 32'h0A000002);

    push_fd();
    run("bne", 32'h1A000002);

    push_fd(); push(4'd10, c_fpu(1'b0)); push(4'd10, c_fpu(1'b0)); push(4'd10, c_fpu(1'b1));
    run("fpu", 32'hEE412003);

    push_fd(); push(4'd6, c_exec(2'b00, 3'b100)); push(4'd8, c_aluwb(1'b1, 1'b0));
    run("mul", 32'hE0010392);

    ALUFlags = 4'b1001;
    push_fd(); push(4'd7, c_exec(2'b01, 3'b001)); push(4'd8, c_aluwb(1'b0, 1'b0));
    run("cmp", 32'hE3510000);
    ALUFlags = 4'b0000;

    push_fd(); push(4'd9, c_branch());
    run("bge", 32'hAA000000);

    push_fd();
    run("blt", 32'hBA000000);

    push_fd(); push(4'd6, c_exec(2'b00, 3'b011)); push(4'd8, c_aluwb(1'b1, 1'b1));
    run("orrs_pc", 32'hE19FF002);

    push_fd(); push(4'd9, c_branch());
    run("bvs", 32'h6A000000);

    push_fd();
    run("nop_mov", 32'hE1A01002);

    push_fd();
    run("cond_nv", 32'hFA000000);

    push_fd(); push(4'd2, c_memadr()); push(4'd3, c_memrd()); push(4'd4, c_memwb(1'b1));
    run("ldr_pc", 32'hE591F004);

    push_fd(); push(4'd7, c_exec(2'b01, 3'b000)); push(4'd8, c_aluwb(1'b0, 1'b0), 1'b1);
    run("add_rst", 32'hE2811005);

    push_fd();
    run("bvs_after_rst", 32'h6A000000);

    push_fd(); push(4'd2, c_memadr()); push(4'd3, c_memrd(), 1'b1);
    run("ldr_rst", 32'hE5912004);

    push_fd(); push(4'd7, c_exec(2'b01, 3'b010)); push(4'd8, c_aluwb(1'b1, 1'b0));
    run("and", 32'hE2011003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
